// File: rtl/quanta_pkg.sv
// Shared types and constants for the quanta core front end.
package quanta_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding req/ack bus, valid/ready IR to decode.
// Optional FETCH_ALIGN_CHECK_EN reports misaligned redirect targets as faults.
module fetch_unit
  import quanta_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSN     = quanta_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_stb,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic            ir_fault,
  output logic [1:0]      dbg_state
);

  // Handshakes: decoder takes ir on a cycle with ir_valid && ir_ready; the bus
  // completes a request on a cycle with mem_stb && mem_ack (ack only while stb).

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n, req_addr, req_addr_n;
  logic [XLEN-1:0] ir_n, ir_pc_n;
  logic            ir_valid_n, ir_fault_n;
  logic            pend, pend_n;      // drained flush must end in a fault entry
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_pc & ~32'h0000_0003;
  assign redir_bad = 1'b0;
`endif

  // rst_n gating drops the strobe the instant reset asserts.
  assign mem_stb   = rst_n && (state == S_REQ || state == S_FLUSH);
  assign mem_addr  = req_addr;
  assign dbg_state = state;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    ir_fault_n = ir_fault;
    pend_n     = pend;
    if (redirect_valid) begin
      pc_n       = redir_tgt;
      ir_valid_n = 1'b0;
      ir_n       = NOP_INSN;
      ir_fault_n = 1'b0;
      if (state != S_HOLD && !mem_ack) begin
        // Request still in flight: drain it, keep its address on the bus.
        state_n = S_FLUSH;
        pend_n  = redir_bad;
      end else if (redir_bad) begin
        state_n    = S_HOLD;
        ir_valid_n = 1'b1;
        ir_fault_n = 1'b1;
        ir_pc_n    = redir_tgt;
        pend_n     = 1'b0;
      end else begin
        req_addr_n = redir_tgt;
        state_n    = S_REQ;
        pend_n     = 1'b0;
      end
    end else begin
      case (state)
        S_REQ: if (mem_ack) begin
          ir_n       = mem_err ? NOP_INSN : mem_data;
          ir_pc_n    = req_addr;
          ir_fault_n = mem_err;
          ir_valid_n = 1'b1;
          pc_n       = pc + 32'd4;
          state_n    = S_HOLD;
        end
        S_HOLD: if (ir_ready) begin
          ir_valid_n = 1'b0;
          ir_fault_n = 1'b0;
          ir_n       = NOP_INSN;
          req_addr_n = pc;
          state_n    = S_REQ;
        end
        S_FLUSH: if (mem_ack) begin
          if (pend) begin
            state_n    = S_HOLD;
            ir_valid_n = 1'b1;
            ir_fault_n = 1'b1;
            ir_n       = NOP_INSN;
            ir_pc_n    = pc;
            pend_n     = 1'b0;
          end else begin
            req_addr_n = pc;
            state_n    = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
      ir       <= NOP_INSN;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      ir_fault <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
      ir_fault <= ir_fault_n;
      pend     <= pend_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; define FETCH_ALIGN_CHECK_EN to cover the misalign fault path.
module tb_fetch_unit;
  import quanta_pkg::*;

  logic        clk, rst_n;
  logic        mem_stb, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ir, ir_pc;
  logic        ir_valid, ir_ready, ir_fault;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_stb(mem_stb), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_err(mem_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_fault(ir_fault), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack_once(input logic [31:0] data, input logic err);
    mem_ack  = 1'b1;
    mem_data = data;
    mem_err  = err;
    step();
    mem_ack  = 1'b0;
    mem_err  = 1'b0;
    mem_data = 32'h0;
  endtask

  task automatic consume();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; mem_data = '0; mem_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
    step(); step();
    chk("rst_stb", {31'b0, mem_stb}, 32'd0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_fault", {31'b0, ir_fault}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, S_REQ});

    // 1: release, slave acks two cycles later
    rst_n = 1'b1;
    #1;
    chk("t1_stb_after_rel", {31'b0, mem_stb}, 32'd1);
    step(); step();
    chk("t1_stb_wait", {31'b0, mem_stb}, 32'd1);
    chk("t1_valid_wait", {31'b0, ir_valid}, 32'd0);
    ack_once(32'h0050_0093, 1'b0);
    chk("t1_valid", {31'b0, ir_valid}, 32'd1);
    chk("t1_ir", ir, 32'h0050_0093);
    chk("t1_ir_pc", ir_pc, 32'h0);
    chk("t1_fault", {31'b0, ir_fault}, 32'd0);

    // 2: decoder stalls five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_ir", ir, 32'h0050_0093);
      chk("t2_ir_pc", ir_pc, 32'h0);
      chk("t2_valid", {31'b0, ir_valid}, 32'd1);
      chk("t2_stb", {31'b0, mem_stb}, 32'd0);
    end
    consume();
    chk("t2_next_addr", mem_addr, 32'h4);
    chk("t2_next_stb", {31'b0, mem_stb}, 32'd1);
    chk("t2_ir_nop", ir, 32'h0000_0013);
    chk("t2_valid_low", {31'b0, ir_valid}, 32'd0);

    ack_once(32'h00a0_0113, 1'b0);
    chk("fetch4_ir_pc", ir_pc, 32'h4);
    chk("fetch4_ir", ir, 32'h00a0_0113);
    consume();
    chk("fetch8_addr", mem_addr, 32'h8);

    // 3: redirect while request to 8 is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    chk("t3_flush_state", {30'b0, dbg_state}, {30'b0, S_FLUSH});
    chk("t3_stb_held", {31'b0, mem_stb}, 32'd1);
    chk("t3_addr_held", mem_addr, 32'h8);
    step();
    chk("t3_addr_held2", mem_addr, 32'h8);
    ack_once(32'hdead_beef, 1'b0);
    chk("t3_no_valid", {31'b0, ir_valid}, 32'd0);
    chk("t3_new_addr", mem_addr, 32'h100);
    chk("t3_new_stb", {31'b0, mem_stb}, 32'd1);

    // 4: bus error response
    ack_once(32'h1234_5678, 1'b1);
    chk("t4_valid", {31'b0, ir_valid}, 32'd1);
    chk("t4_fault", {31'b0, ir_fault}, 32'd1);
    chk("t4_ir_nop", ir, 32'h0000_0013);
    chk("t4_ir_pc", ir_pc, 32'h100);
    consume();
    chk("t4_pc_adv", mem_addr, 32'h104);

    // 5: redirect and ir_ready in the same cycle
    ack_once(32'h0000_0033, 1'b0);
    chk("t5_ir_pc", ir_pc, 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h200; ir_ready = 1'b1;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0; ir_ready = 1'b0;
    chk("t5_valid", {31'b0, ir_valid}, 32'd0);
    chk("t5_ir_nop", ir, 32'h0000_0013);
    chk("t5_addr", mem_addr, 32'h200);
    chk("t5_stb", {31'b0, mem_stb}, 32'd1);

    // PC wrap: redirect with ack in the same cycle goes straight to the new target
    mem_ack = 1'b1; mem_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    mem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'b0, ir_valid}, 32'd0);
    ack_once(32'h0000_0013, 1'b0);
    chk("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
    consume();
    chk("wrap_next_addr", mem_addr, 32'h0);

    // 6: misaligned redirect target
    mem_ack = 1'b1; mem_data = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    mem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_stb", {31'b0, mem_stb}, 32'd0);
    chk("t6_valid", {31'b0, ir_valid}, 32'd1);
    chk("t6_fault", {31'b0, ir_fault}, 32'd1);
    chk("t6_ir_nop", ir, 32'h0000_0013);
    chk("t6_ir_pc", ir_pc, 32'h102);
`else
    chk("t6_forced_addr", mem_addr, 32'h100);
    chk("t6_stb", {31'b0, mem_stb}, 32'd1);
    chk("t6_valid", {31'b0, ir_valid}, 32'd0);
`endif

    // Reset mid-transaction drops the strobe without a clock edge
    consume();
    chk("mid_stb_before", {31'b0, mem_stb}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_stb_async", {31'b0, mem_stb}, 32'd0);
    chk("mid_valid", {31'b0, ir_valid}, 32'd0);
    chk("mid_addr", mem_addr, 32'h0);
    chk("mid_state", {30'b0, dbg_state}, {30'b0, S_REQ});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
